iobs_posted_queue: RTL and testbench

Parametrised FSB-to-IOB bridge front end. It replaces the fixed two-level posted-write FIFO with a DEPTH-entry queue of I/O transfer descriptors, and a programmable I/O wait-state count replaces the 0/1 wait-state select. The block sits between the MC68HC000 FSB cycle logic and the IOB master controller. It accepts posted writes while the queue has room and holds non-posted cycles until every earlier entry has drained. It drives the external address/data latch bank slot-by-slot.

---
 rtl/iobs_posted_queue_if.sv | 51 +++++
 rtl/iobs_posted_queue.sv | 192 +++++++++++++++++++
 tb/tb_iobs_posted_queue.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/iobs_posted_queue_if.sv
// iobs_posted_queue_if
//   Bundles the FSB cycle-logic signals and the IOB master signals seen by
//   the posted-write queue. CLK and nRESET stay plain ports on the block.
//
//   Handshakes: an FSB I/O cycle is a request while BACT && IOCS. The block
//   answers once per cycle with IOPWReady (posted write taken), IONPReady
//   (non-posted cycle done) or nBERR_FSB=0 (bus error). Each answer holds
//   until BACT falls. On the IOB side IOREQ stays high until IOACT is seen
//   (registered). The transfer ends with an IODONEin pulse followed by
//   IOACT low.
//
//   Modports: slave = the queue block, master = the FSB/IOB side driving it.
//   IssueState is the issue FSM state (0 IDLE, 1 LOAD, 2 REQ, 3 ACT) for debug.
interface iobs_posted_queue_if #(
  parameter int DEPTH = 4,
  parameter int WSW   = 2
);
  localparam int AW = $clog2(DEPTH);

  // FSB side
  logic             BACT, BACTr;
  logic             nAS, nWE, nLDS, nUDS;
  logic             IOCS, IORealCS, IOPWCS;
  logic [WSW-1:0]   IOWS;
  logic             SlowdownIOWriteGate;
  logic             IONPReady, IOPWReady, nBERR_FSB, nDinOE;
  logic             PWErr, PWErrClr;
  // latch bank control
  logic [DEPTH-1:0] WrSlotLE;
  logic [AW-1:0]    RdSlot;
  logic [AW:0]      Level;
  // IOB master side
  logic             IOREQ, IORW, IOL0, IOU0, ALE0;
  logic             IOACT, IODONEin, nBERR_IOB;
  // debug
  logic [1:0]       IssueState;

  modport slave (
    input  BACT, BACTr, nAS, nWE, nLDS, nUDS, IOCS, IORealCS, IOPWCS, IOWS,
           SlowdownIOWriteGate, PWErrClr, IOACT, IODONEin, nBERR_IOB,
    output IONPReady, IOPWReady, nBERR_FSB, nDinOE, PWErr, WrSlotLE, RdSlot,
           Level, IOREQ, IORW, IOL0, IOU0, ALE0, IssueState
  );

  modport master (
    output BACT, BACTr, nAS, nWE, nLDS, nUDS, IOCS, IORealCS, IOPWCS, IOWS,
           SlowdownIOWriteGate, PWErrClr, IOACT, IODONEin, nBERR_IOB,
    input  IONPReady, IOPWReady, nBERR_FSB, nDinOE, PWErr, WrSlotLE, RdSlot,
           Level, IOREQ, IORW, IOL0, IOU0, ALE0, IssueState
  );
endinterface

// File: rtl/iobs_posted_queue.sv
// iobs_posted_queue
//   FSB-to-IOB bridge front end: a DEPTH-entry queue of I/O transfer
//   descriptors {RW, L, U, NP}. Posted writes are taken while the queue has
//   room; non-posted cycles (reads, writes without IOPWCS) are enqueued only
//   once the queue is empty and the issue FSM is idle, and are answered when
//   they pop. The external address/data latch bank is written through the
//   one-hot WrSlotLE and read out through RdSlot.
//
//   Ports: CLK, nRESET (async, active low), io (iobs_posted_queue_if.slave).
//   Parameters: DEPTH (power of two, 2..16), WSW (IOWS width).
//   Optional feature macro: IOBS_PWERR_EN -- sticky posted-write error
//   (PWErr) reported as a bus error on the next FSB I/O request. Without it
//   PWErr is tied low and PWErrClr is ignored.
module iobs_posted_queue #(
  parameter int DEPTH = 4,
  parameter int WSW   = 2
) (
  input logic                 CLK,
  input logic                 nRESET,
  iobs_posted_queue_if.slave  io
);
  localparam int AW   = $clog2(DEPTH);
  localparam int NSTG = 1 << WSW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_REQ = 2'd2, S_ACT = 2'd3} state_t;

  state_t           state;
  logic [3:0]       entry_q [DEPTH];  // {RW, L, U, NP}
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      level;
  logic [DEPTH-1:0] wr_le;
  logic             sent, pw_ready, np_ready, berr_fsb;
  logic             ioreq, ale0, iorw, iol0, iou0, cur_np;
  logic             ioact_r, done_seen, err_seen;
  logic             done_neg;
  logic [NSTG-1:1]  done_stg;
  logic [NSTG-1:0]  done_chain;
  logic             iodone;
  logic             pw_err, err_term;
  logic             req, is_pw_cycle, push_pw, push_np, push, pop;
  logic [3:0]       new_entry;

  assign req         = io.BACT && io.IOCS && !sent;
  assign is_pw_cycle = io.IOPWCS && !io.nWE;
  assign push_pw     = req && !err_term && is_pw_cycle && (level < LVL_FULL);
  assign push_np     = req && !err_term && !is_pw_cycle && (level == '0) && (state == S_IDLE);
  assign push        = push_pw || push_np;
  // Pop only after IODONE has been registered, so every IOWS stage adds
  // exactly one cycle to the completion.
  assign pop         = (state == S_ACT) && done_seen && !ioact_r;
  assign new_entry   = {(io.SlowdownIOWriteGate && !io.IORealCS) ? 1'b1 : io.nWE,
                        !io.nLDS, !io.nUDS, push_np};

  // IODONE: captured on the falling edge, then IOWS extra rising-edge stages.
  always_ff @(negedge CLK or negedge nRESET) begin
    if (!nRESET) done_neg <= 1'b0;
    else         done_neg <= io.IODONEin;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      done_stg <= '0;
      ioact_r  <= 1'b0;
    end else begin
      done_stg[1] <= done_neg;
      for (int i = 2; i < NSTG; i++) done_stg[i] <= done_stg[i-1];
      ioact_r <= io.IOACT;
    end
  end

  assign done_chain = {done_stg, done_neg};
  assign iodone     = done_chain[io.IOWS];

  // Queue storage and pointers
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      wr_le <= '0;
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= 4'b1000;
    end else begin
      wr_le <= '0;
      if (push) begin
        entry_q[wp] <= new_entry;
        wr_le       <= {{(DEPTH-1){1'b0}}, 1'b1} << wp;
        wp          <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
    end
  end

  // Issue FSM with registered IOB outputs
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      ioreq     <= 1'b0;
      ale0      <= 1'b0;
      iorw      <= 1'b1;
      iol0      <= 1'b0;
      iou0      <= 1'b0;
      cur_np    <= 1'b0;
      done_seen <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (level != '0) begin
          {iorw, iol0, iou0, cur_np} <= entry_q[rp];
          ioreq <= 1'b1;
          ale0  <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: state <= S_REQ;
        S_REQ: if (ioact_r) begin
          ioreq <= 1'b0;
          ale0  <= 1'b0;
          state <= S_ACT;
        end
        S_ACT: if (pop) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if ((state == S_REQ || state == S_ACT) && iodone) begin
        done_seen <= 1'b1;
        err_seen  <= !io.nBERR_IOB;
      end
      if (pop) begin
        done_seen <= 1'b0;
        err_seen  <= 1'b0;
      end
    end
  end

  // FSB answers; each holds until BACT falls.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sent     <= 1'b0;
      pw_ready <= 1'b0;
      np_ready <= 1'b0;
      berr_fsb <= 1'b1;
    end else begin
      if (!io.BACT) begin
        sent     <= 1'b0;
        pw_ready <= 1'b0;
        np_ready <= 1'b0;
        berr_fsb <= 1'b1;
      end
      if (push)    sent     <= 1'b1;
      if (push_pw) pw_ready <= 1'b1;
      if (pop && cur_np) begin
        if (err_seen) berr_fsb <= 1'b0;
        else          np_ready <= 1'b1;
      end
      if (err_term) begin
        sent     <= 1'b1;
        berr_fsb <= 1'b0;
      end
    end
  end

`ifdef IOBS_PWERR_EN
  assign err_term = req && pw_err;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET)                          pw_err <= 1'b0;
    else if (pop && !cur_np && err_seen)  pw_err <= 1'b1;
    else if (io.PWErrClr || err_term)     pw_err <= 1'b0;
  end
`else
  logic unused_pwerr_clr;
  assign unused_pwerr_clr = io.PWErrClr;
  assign err_term = 1'b0;
  assign pw_err   = 1'b0;
`endif

  assign io.IONPReady  = np_ready;
  assign io.IOPWReady  = pw_ready;
  assign io.nBERR_FSB  = berr_fsb;
  assign io.nDinOE     = !(!io.nAS && io.BACTr && io.IORealCS && io.nWE);
  assign io.PWErr      = pw_err;
  assign io.WrSlotLE   = wr_le;
  assign io.RdSlot     = rp;
  assign io.Level      = level;
  assign io.IOREQ      = ioreq;
  assign io.IORW       = iorw;
  assign io.IOL0       = iol0;
  assign io.IOU0       = iou0;
  assign io.ALE0       = ale0;
  assign io.IssueState = state;
endmodule

// File: tb/tb_iobs_posted_queue.sv
module tb_iobs_posted_queue;
  localparam int DEPTH = 4;
  localparam int WSW   = 2;
  localparam int SBW   = 5;  // {slot[1:0], rw, l, u}
`ifdef IOBS_PWERR_EN
  localparam bit PWERR_EXP = 1'b1;
`else
  localparam bit PWERR_EXP = 1'b0;
`endif

  logic CLK;
  logic nRESET;
  int   checks = 0;
  int   errors = 0;
  logic [SBW-1:0] exp_q[$];
  logic [1:0]     tb_wp;
  int             lat0, lat3, lat_tmp;

  iobs_posted_queue_if #(.DEPTH(DEPTH), .WSW(WSW)) bus();

  iobs_posted_queue #(.DEPTH(DEPTH), .WSW(WSW)) dut (
    .CLK    (CLK),
    .nRESET (nRESET),
    .io     (bus)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic fsb_start(input bit wr, input bit pwcs, input bit real_cs, input bit slow);
    logic l, u, rw;
    l = 1'($urandom_range(0, 1));
    u = 1'($urandom_range(0, 1));
    bus.BACT = 1'b1; bus.BACTr = 1'b1; bus.IOCS = 1'b1; bus.nAS = 1'b0;
    bus.nWE = !wr; bus.IOPWCS = pwcs; bus.IORealCS = real_cs;
    bus.SlowdownIOWriteGate = slow; bus.nLDS = !l; bus.nUDS = !u;
    rw = (slow && !real_cs) ? 1'b1 : !wr;
    exp_q.push_back({tb_wp, rw, l, u});
    tb_wp = tb_wp + 2'd1;
  endtask

  task automatic fsb_end();
    bus.BACT = 1'b0; bus.BACTr = 1'b0; bus.IOCS = 1'b0; bus.nAS = 1'b1;
    bus.nWE = 1'b1; bus.IOPWCS = 1'b0; bus.nLDS = 1'b1; bus.nUDS = 1'b1;
    bus.SlowdownIOWriteGate = 1'b0;
    tick();
  endtask

  task automatic pw_write(input bit real_cs, input bit slow);
    logic [3:0] one;
    logic [1:0] s;
    one = 4'b0001;
    s = tb_wp;
    fsb_start(1'b1, 1'b1, real_cs, slow);
    tick();
    chk("pw_ready", bus.IOPWReady, 1);
    chk("wr_slot_le", bus.WrSlotLE, one << s);
    fsb_end();
  endtask

  // IOB master model: accept the pending request, compare it with the
  // scoreboard head, run one transfer and wait for the pop.
  task automatic serve(input bit berr, output int lat);
    logic [SBW-1:0] e;
    int n;
    n = 0;
    while (bus.IOREQ !== 1'b1 && n < 20) begin tick(); n++; end
    chk("ioreq_wait", bus.IOREQ, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    chk("issue_desc", {bus.RdSlot, bus.IORW, bus.IOL0, bus.IOU0}, e);
    chk("ale0", bus.ALE0, 1);
    bus.IOACT = 1'b1; tick(); tick();
    bus.IOACT = 1'b0; bus.IODONEin = 1'b1; bus.nBERR_IOB = !berr; tick();
    bus.IODONEin = 1'b0;
    lat = 1;
    n = 0;
    while (bus.IssueState !== 2'd0 && n < 40) begin tick(); lat++; n++; end
    chk("pop_wait", bus.IssueState, 0);
    bus.nBERR_IOB = 1'b1;
  endtask

  task automatic pulse_reset();
    tick();
    nRESET = 1'b0;
    #2;
    nRESET = 1'b1;
    exp_q.delete();
    tb_wp = 2'd0;
    tick();
  endtask

  initial begin
    nRESET = 1'b0; tb_wp = 2'd0;
    bus.BACT = 0; bus.BACTr = 0; bus.nAS = 1; bus.nWE = 1; bus.nLDS = 1; bus.nUDS = 1;
    bus.IOCS = 0; bus.IORealCS = 0; bus.IOPWCS = 0; bus.IOWS = '0;
    bus.SlowdownIOWriteGate = 0; bus.PWErrClr = 0;
    bus.IOACT = 0; bus.IODONEin = 0; bus.nBERR_IOB = 1;
    tick(); tick();

    // reset values
    chk("rst_ioreq", bus.IOREQ, 0);
    chk("rst_ale0", bus.ALE0, 0);
    chk("rst_iorw", bus.IORW, 1);
    chk("rst_iol0_iou0", {bus.IOL0, bus.IOU0}, 0);
    chk("rst_wrslotle", bus.WrSlotLE, 0);
    chk("rst_rdslot", bus.RdSlot, 0);
    chk("rst_level", bus.Level, 0);
    chk("rst_ready", {bus.IONPReady, bus.IOPWReady}, 0);
    chk("rst_nberr_fsb", bus.nBERR_FSB, 1);
    chk("rst_pwerr", bus.PWErr, 0);
    chk("rst_state", bus.IssueState, 0);
    nRESET = 1'b1;
    tick();

    // 1: five posted writes with IOACT held low; the fifth stalls
    for (int i = 0; i < 4; i++) pw_write(1'b1, 1'b0);
    fsb_start(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("full_no_ready", bus.IOPWReady, 0);
    chk("full_level", bus.Level, 4);
    chk("full_ioreq", bus.IOREQ, 1);
    chk("full_no_le", bus.WrSlotLE, 0);
    serve(1'b0, lat_tmp);
    chk("after_pop_level", bus.Level, 3);
    chk("after_pop_no_ready", bus.IOPWReady, 0);
    tick();
    chk("refill_ready", bus.IOPWReady, 1);
    chk("refill_level", bus.Level, 4);
    chk("refill_le", bus.WrSlotLE, 4'b0001);
    fsb_end();
    for (int i = 0; i < 4; i++) serve(1'b0, lat_tmp);
    chk("drain_level", bus.Level, 0);

    // 2: two posted writes then a read, read issues third
    pulse_reset();
    pw_write(1'b1, 1'b0);
    pw_write(1'b1, 1'b0);
    fsb_start(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("read_ndinoe", bus.nDinOE, 0);
    serve(1'b0, lat_tmp);
    chk("np_wait1", bus.IONPReady, 0);
    serve(1'b0, lat_tmp);
    chk("np_wait2", bus.IONPReady, 0);
    serve(1'b0, lat0);
    chk("np_ready", bus.IONPReady, 1);
    chk("np_berr_high", bus.nBERR_FSB, 1);
    tick();
    chk("np_no_reissue", bus.Level, 0);
    fsb_end();
    chk("np_ready_clear", bus.IONPReady, 0);

    // 3: IOWS=3 adds three cycles to completion
    bus.IOWS = 2'd3;
    fsb_start(1'b0, 1'b0, 1'b1, 1'b0);
    serve(1'b0, lat3);
    chk("np_ready_ws3", bus.IONPReady, 1);
    chk("iows_delta", lat3 - lat0, 3);
    fsb_end();
    bus.IOWS = 2'd0;

    // 4: non-posted write terminated with a bus error
    fsb_start(1'b1, 1'b0, 1'b1, 1'b0);
    #1;
    chk("write_ndinoe", bus.nDinOE, 1);
    serve(1'b1, lat_tmp);
    chk("berr_fsb_low", bus.nBERR_FSB, 0);
    chk("berr_no_ready", bus.IONPReady, 0);
    fsb_end();
    chk("berr_fsb_release", bus.nBERR_FSB, 1);

    // 5: slowdown gate forces RW=1 on a posted write to a non-real device
    pw_write(1'b0, 1'b1);
    serve(1'b0, lat_tmp);
    pw_write(1'b0, 1'b0);
    serve(1'b0, lat_tmp);

    // posted-write bus error
    pw_write(1'b1, 1'b0);
    serve(1'b1, lat_tmp);
    chk("pw_err_flag", bus.PWErr, PWERR_EXP);
    chk("pw_err_no_fsb_berr", bus.nBERR_FSB, 1);
    bus.PWErrClr = 1'b1; tick(); bus.PWErrClr = 1'b0;
    chk("pw_err_clear", bus.PWErr, 0);

    // 6: reset in ACT with three entries queued
    for (int i = 0; i < 3; i++) pw_write(1'b1, 1'b0);
    bus.IOACT = 1'b1; tick(); tick(); tick();
    chk("mid_state_act", bus.IssueState, 3);
    chk("mid_level", bus.Level, 3);
    nRESET = 1'b0;
    #2;
    chk("async_ioreq", bus.IOREQ, 0);
    chk("async_level", bus.Level, 0);
    chk("async_rdslot", bus.RdSlot, 0);
    chk("async_state", bus.IssueState, 0);
    bus.IOACT = 1'b0;
    exp_q.delete();
    tb_wp = 2'd0;
    tick();
    nRESET = 1'b1;
    tick();
    pw_write(1'b1, 1'b0);
    serve(1'b0, lat_tmp);
    chk("final_level", bus.Level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
